// File: rtl/spi_cfg_bridge_pkg.sv
// Shared opcodes, FSM state encoding and STATUS byte layout for the SPI
// configuration bridge.
package spi_cfg_bridge_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  // Bit positions inside the STATUS byte.
  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_START = 3'd5,
    ST_STAT  = 3'd6,
    ST_DROP  = 3'd7
  } state_e;

  // Assemble the STATUS byte from the live flags.
  function automatic logic [7:0] status_byte(input logic fifo_empty, input logic done);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_EMPTY_BIT] = fifo_empty;
    b[STAT_DONE_BIT]  = done;
    return b;
  endfunction

endpackage

// File: rtl/spi_cfg_bridge_fifo.sv
// Single-clock FIFO used as the read-back buffer. Push when full and pop when
// empty are ignored; flush empties it in one cycle and wins over push.
module sync_fifo_sc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: extra MSB distinguishes full from empty.
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_cfg_bridge.sv
// SPI mode-0 target that turns opcode/address/data frames into one-cycle
// configuration strobes, streams read-back words out on sdout and reports
// execution status. Everything runs on clkOut; SPI pins are oversampled.
//
// Handshake: cfg_valid is a single-cycle strobe with no ready; the array must
// accept every strobe. rd_valid/rd_data carry one response per issued read,
// at any later cycle; responses with no read outstanding, or arriving while
// the buffer is full, are discarded and never stall the bridge.
module spi_cfg_bridge
  import spi_cfg_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int RD_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clkOut,
  input  logic                  reset_network,
  input  logic                  chip_en,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  sdin,
  output logic                  sdout,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_valid,
  output logic                  cfg_rw,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  start_exec,
  input  logic                  exec_end,
  output logic [2:0]            dbg_state
);

  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, sdin_sync_q;
  logic sck_prev_q, ss_prev_q;
  logic sck_s, ss_s, sdin_s;
  logic sck_rise, sck_fall, ss_rise, ss_fall, abort;

  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         shift_q, shift_d, shift_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rd_word;
  logic                  is_write_q, is_write_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  done_q, done_d, done_clr;
  logic                  exec_prev_q;
  logic                  sdout_q, sdout_d;
  logic [ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic [DATA_WIDTH-1:0] cfg_wdata_q, cfg_wdata_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic                  cfg_rw_q, cfg_rw_d;
  logic                  start_exec_q, start_exec_d;

  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  // Input synchronisers and previous-value flops for edge detection.
  always_ff @(posedge clkOut) begin
    if (reset_network) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      sdin_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      exec_prev_q <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      exec_prev_q <= exec_end;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sdin_s   = sdin_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign abort    = ss_rise | ~chip_en;

  // Next-state, framing, strobe generation and read-back streaming.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    shift_nxt    = {shift_q[SW-2:0], sdin_s};
    addr_d       = addr_q;
    tx_d         = tx_q;
    rd_word      = '1;
    is_write_d   = is_write_q;
    rd_pend_d    = rd_pend_q & ~rd_valid;
    done_clr     = 1'b0;
    sdout_d      = sdout_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_wdata_d  = cfg_wdata_q;
    cfg_valid_d  = 1'b0;
    cfg_rw_d     = cfg_rw_q;
    start_exec_d = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    fifo_push    = rd_valid & rd_pend_q & (state_q == ST_RDATA) & ~abort;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (sck_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(7)) begin
            bit_cnt_d = '0;
            case (shift_nxt[7:0])
              OP_WRITE: begin
                state_d    = ST_ADDR;
                is_write_d = 1'b1;
              end
              OP_READ: begin
                state_d    = ST_ADDR;
                is_write_d = 1'b0;
              end
              OP_START: begin
                state_d      = ST_START;
                start_exec_d = 1'b1;
              end
              OP_STATUS: begin
                state_d  = ST_STAT;
                tx_d     = DATA_WIDTH'(status_byte(fifo_empty, done_q)) << (DATA_WIDTH - 8);
                done_clr = 1'b1;
              end
              default: state_d = ST_DROP;
            endcase
          end
        end
      end
      ST_ADDR: begin
        if (sck_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(ADDR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            addr_d    = shift_nxt[ADDR_WIDTH-1:0];
            state_d   = is_write_q ? ST_WDATA : ST_RDATA;
          end
        end
      end
      ST_WDATA: begin
        if (sck_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d   = '0;
            cfg_valid_d = 1'b1;
            cfg_rw_d    = 1'b1;
            cfg_addr_d  = addr_q;
            cfg_wdata_d = shift_nxt[DATA_WIDTH-1:0];
            addr_d      = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_RDATA: begin
        if (sck_rise) begin
          bit_cnt_d = (bit_cnt_q == CW'(DATA_WIDTH - 1)) ? '0 : bit_cnt_q + CW'(1);
        end
        // Word boundary: the first falling edge of each word loads the next
        // buffered word, or all-ones when nothing has arrived in time.
        if (sck_fall) begin
          if (bit_cnt_q == '0) begin
            if (!fifo_empty) begin
              rd_word  = fifo_rdata;
              fifo_pop = 1'b1;
            end
            sdout_d = rd_word[DATA_WIDTH-1];
            tx_d    = rd_word << 1;
          end else begin
            sdout_d = tx_q[DATA_WIDTH-1];
            tx_d    = tx_q << 1;
          end
        end
        // Keep one read in flight whenever the buffer has room.
        if (!rd_pend_q && !fifo_full) begin
          cfg_valid_d = 1'b1;
          cfg_rw_d    = 1'b0;
          cfg_addr_d  = addr_q;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          rd_pend_d   = 1'b1;
        end
      end
      ST_STAT: begin
        if (sck_fall) begin
          sdout_d = tx_q[DATA_WIDTH-1];
          tx_d    = tx_q << 1;
        end
      end
      default: ; // ST_START and ST_DROP wait for the frame to end
    endcase

    // End of frame or disabled chip: drop everything in flight.
    if (abort) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = '0;
      rd_pend_d    = 1'b0;
      sdout_d      = 1'b0;
      cfg_valid_d  = 1'b0;
      start_exec_d = 1'b0;
      fifo_pop     = 1'b0;
      fifo_flush   = 1'b1;
    end
    if (!chip_en) begin
      cfg_addr_d  = '0;
      cfg_wdata_d = '0;
      cfg_rw_d    = 1'b0;
    end

    // Sticky done flag: a set in the same cycle as a clear wins.
    done_d = done_q;
    if (done_clr) done_d = 1'b0;
    if (exec_end && !exec_prev_q) done_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clkOut) begin
    if (reset_network) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      tx_q         <= '0;
      is_write_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      done_q       <= 1'b0;
      sdout_q      <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_wdata_q  <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_rw_q     <= 1'b0;
      start_exec_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      is_write_q   <= is_write_d;
      rd_pend_q    <= rd_pend_d;
      done_q       <= done_d;
      sdout_q      <= sdout_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_wdata_q  <= cfg_wdata_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_rw_q     <= cfg_rw_d;
      start_exec_q <= start_exec_d;
    end
  end

  sync_fifo_sc #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RD_DEPTH)
  ) u_rd_fifo (
    .clk   (clkOut),
    .rst   (reset_network),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (rd_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sdout      = sdout_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_wdata  = cfg_wdata_q;
  assign cfg_valid  = cfg_valid_q;
  assign cfg_rw     = cfg_rw_q;
  assign start_exec = start_exec_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_cfg_bridge.sv
// Directed bench for spi_cfg_bridge: a vector table of write frames plus
// hand-written read, underrun, abort, start/status, disable and reset cases.
module tb_spi_cfg_bridge;

  localparam int HALF = 10; // clkOut cycles per sck half period

  logic        clk;
  logic        reset_network;
  logic        chip_en;
  logic        ss;
  logic        sck;
  logic        sdin;
  logic        sdout;
  logic [15:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_valid;
  logic        cfg_rw;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        start_exec;
  logic        exec_end;
  logic [2:0]  dbg_state;

  spi_cfg_bridge dut (
    .clkOut        (clk),
    .reset_network (reset_network),
    .chip_en       (chip_en),
    .ss            (ss),
    .sck           (sck),
    .sdin          (sdin),
    .sdout         (sdout),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_valid     (cfg_valid),
    .cfg_rw        (cfg_rw),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .start_exec    (start_exec),
    .exec_end      (exec_end),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  logic        resp_en = 1'b0;
  int          resp_cnt = 0;
  logic [15:0] resp_data = '0;
  logic [32:0] act_q[$]; // {rw, addr, wdata} of every observed strobe
  logic [32:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
  } wvec_t;
  wvec_t wv[4];

  function automatic logic [15:0] mem_of(input logic [15:0] a);
    if (a == 16'hFFFF) return 16'h5A5A;
    if (a == 16'h0000) return 16'hC3C3;
    return 16'hBEAD;
  endfunction

  // Strobe monitor and array read responder (3-cycle latency), off the active edge.
  always @(negedge clk) begin
    if (cfg_valid) act_q.push_back({cfg_rw, cfg_addr, cfg_wdata});
    if (start_exec) start_cnt++;
    rd_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        rd_valid = 1'b1;
        rd_data  = resp_data;
      end
    end
    if (cfg_valid && !cfg_rw && resp_en) begin
      resp_cnt  = 3;
      resp_data = mem_of(cfg_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    ss = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic spi_end();
    clk_wait(HALF);
    ss = 1'b1;
    clk_wait(4 * HALF);
  endtask

  // Mode 0, MSB first: drive sdin while sck low, sample sdout before rising.
  task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sdin = tx[i];
      clk_wait(HALF);
      rx = {rx[30:0], sdout};
      sck = 1'b1;
      clk_wait(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic pulse_exec_end();
    exec_end = 1'b1;
    clk_wait(1);
    exec_end = 1'b0;
    clk_wait(4);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_strobes(input string name);
    check({name, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_strobe%0d", name, i), 64'(act_q[i]), 64'(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_sdout"}, 64'(sdout), 64'd0);
    check({name, "_cfg_addr"}, 64'(cfg_addr), 64'd0);
    check({name, "_cfg_wdata"}, 64'(cfg_wdata), 64'd0);
    check({name, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
    check({name, "_cfg_rw"}, 64'(cfg_rw), 64'd0);
    check({name, "_start_exec"}, 64'(start_exec), 64'd0);
    check({name, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rx;
    logic [31:0] rx0;
    logic [31:0] rx1;

    wv[0] = '{addr: 16'h0010, d0: 16'hABCD, d1: 16'h1234, exp_a0: 16'h0010, exp_a1: 16'h0011};
    wv[1] = '{addr: 16'hFFFF, d0: 16'h0001, d1: 16'h8000, exp_a0: 16'hFFFF, exp_a1: 16'h0000};
    wv[2] = '{addr: 16'h7FFF, d0: 16'hA5A5, d1: 16'h5A5A, exp_a0: 16'h7FFF, exp_a1: 16'h8000};
    wv[3] = '{addr: 16'h00FF, d0: 16'hFFFF, d1: 16'h0000, exp_a0: 16'h00FF, exp_a1: 16'h0100};

    reset_network = 1'b1;
    chip_en  = 1'b1;
    ss       = 1'b1;
    sck      = 1'b0;
    sdin     = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    exec_end = 1'b0;
    clk_wait(5);
    reset_network = 1'b0;
    clk_wait(5);
    check_idle_outputs("reset");

    // Table-driven write frames: two words each, with address increment/wrap.
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back({1'b1, wv[v].exp_a0, wv[v].d0});
      exp_q.push_back({1'b1, wv[v].exp_a1, wv[v].d1});
      spi_begin();
      spi_bits(32'h01, 8, rx);
      spi_bits(32'(wv[v].addr), 16, rx);
      spi_bits(32'(wv[v].d0), 16, rx);
      spi_bits(32'(wv[v].d1), 16, rx);
      spi_end();
      check_strobes($sformatf("wr%0d", v));
    end

    // Read two words from 0xFFFF: address wraps, data streams out.
    act_q.delete();
    resp_en = 1'b1;
    spi_begin();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'hFFFF, 16, rx);
    spi_bits(32'h0, 16, rx0);
    spi_bits(32'h0, 16, rx1);
    spi_end();
    check("rd_word0", 64'(rx0[15:0]), 64'h5A5A);
    check("rd_word1", 64'(rx1[15:0]), 64'hC3C3);
    check("rd_count_ge2", 64'(act_q.size() >= 2), 64'd1);
    if (act_q.size() >= 2) begin
      check("rd_strobe0", 64'(act_q[0][32:16]), 64'h0FFFF);
      check("rd_strobe1", 64'(act_q[1][32:16]), 64'h00000);
    end
    act_q.delete();

    // Underrun: responses withheld, both words read back as all-ones.
    resp_en = 1'b0;
    spi_begin();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0040, 16, rx);
    spi_bits(32'h0, 16, rx0);
    spi_bits(32'h0, 16, rx1);
    spi_end();
    check("ur_word0", 64'(rx0[15:0]), 64'hFFFF);
    check("ur_word1", 64'(rx1[15:0]), 64'hFFFF);
    exp_q.push_back({1'b0, 16'h0040, 16'h1234});
    check("ur_count", 64'(act_q.size()), 64'd1);
    if (act_q.size() >= 1) check("ur_strobe0", 64'(act_q[0][32:16]), 64'(exp_q[0][32:16]));
    act_q.delete();
    exp_q.delete();
    resp_en = 1'b1;

    // Next frame after underrun decodes normally.
    exp_q.push_back({1'b1, 16'h0100, 16'hBEEF});
    spi_begin();
    spi_bits(32'h01, 8, rx);
    spi_bits(32'h0100, 16, rx);
    spi_bits(32'hBEEF, 16, rx);
    spi_end();
    check_strobes("post_ur");

    // Abort after 9 data bits, then a clean write.
    spi_begin();
    spi_bits(32'h01, 8, rx);
    spi_bits(32'h0020, 16, rx);
    spi_bits(32'h1FF, 9, rx);
    spi_end();
    check_strobes("abort");
    exp_q.push_back({1'b1, 16'h0020, 16'h1111});
    spi_begin();
    spi_bits(32'h01, 8, rx);
    spi_bits(32'h0020, 16, rx);
    spi_bits(32'h1111, 16, rx);
    spi_end();
    check_strobes("post_abort");

    // START, exec_end pulse, two STATUS reads.
    start_cnt = 0;
    spi_begin();
    spi_bits(32'h03, 8, rx);
    spi_end();
    check("start_pulses", 64'(start_cnt), 64'd1);
    pulse_exec_end();
    spi_begin();
    spi_bits(32'h04, 8, rx);
    spi_bits(32'h0, 8, rx);
    spi_end();
    check("status1", 64'(rx[7:0]), 64'h03);
    spi_begin();
    spi_bits(32'h04, 8, rx);
    spi_bits(32'h0, 8, rx);
    spi_end();
    check("status2", 64'(rx[7:0]), 64'h02);
    check("start_pulses_after", 64'(start_cnt), 64'd1);

    // Unknown opcode is dropped: no strobes, no start.
    start_cnt = 0;
    spi_begin();
    spi_bits(32'h7E, 8, rx);
    spi_bits(32'hFFFF, 16, rx);
    spi_bits(32'h0301, 16, rx);
    spi_end();
    check_strobes("drop");
    check("drop_start", 64'(start_cnt), 64'd0);

    // chip_en low mid-frame: outputs idle, rest of frame ignored.
    spi_begin();
    spi_bits(32'h01, 8, rx);
    spi_bits(32'h0030, 16, rx);
    spi_bits(32'hAA, 8, rx);
    chip_en = 1'b0;
    clk_wait(6);
    check_idle_outputs("chip_dis");
    spi_bits(32'h55, 8, rx);
    chip_en = 1'b1;
    spi_bits(32'h1234, 16, rx);
    spi_end();
    check_strobes("chip_dis");

    // Reset mid-READ: outputs, done flag and FIFO back to reset state.
    pulse_exec_end();
    spi_begin();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0050, 16, rx);
    spi_bits(32'h0, 4, rx);
    reset_network = 1'b1;
    clk_wait(3);
    reset_network = 1'b0;
    clk_wait(1);
    check_idle_outputs("rst_mid");
    act_q.delete();
    ss = 1'b1;
    clk_wait(4 * HALF);
    check_strobes("rst_mid");
    spi_begin();
    spi_bits(32'h04, 8, rx);
    spi_bits(32'h0, 8, rx);
    spi_end();
    check("rst_status", 64'(rx[7:0]), 64'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
